game2048_nxn_ctrl: RTL and testbench
====================================

// Module: game2048_nxn_ctrl
// PURPOSE
//  Parametrised 2048 engine: NxN registered board, sequential per-line slide/merge,
//  internal LFSR tile spawner, win/lose detection, and a valid/ready move interface.
//  Sits between the input decoder (direction source) and the board renderer/score display.
// PARAMETERS
//  N        4       board edge length (N>=2)
//  TILE_W   4       exponent width per cell; 0 = empty, k = value 2^k
//  WIN_EXP  11      exponent that wins (2048); must be < 2^TILE_W
//  SCORE_W  20      score width, saturating
//  SEED     16'hACE1 LFSR reset value (non-zero)
// PORTS
//  clk         in   1            clock
//  rst         in   1            synchronous, active-high reset
//  start       in   1            pulse: clear board, begin new game
//  dir_valid   in   1            move request valid
//  dir         in   4            one-hot: 0001 up, 0010 down, 0100 left, 1000 right
//  dir_ready   out  1            engine accepts a move this cycle
//  load_en     in   1            test/preset: load load_board
//  load_board  in   N*N*TILE_W   preset board image
//  board       out  N*N*TILE_W   cell (r,c) at [(r*N+c)*TILE_W +: TILE_W]; r0 top, c0 left
//  score       out  SCORE_W      accumulated score
//  game_state  out  2            00 not_playing, 01 playing, 10 win, 11 lose
//  busy        out  1            engine mid-operation
// BEHAVIOUR
//  Reset: board=0, score=0, game_state=00, dir_ready=0, busy=0, LFSR=SEED, FSM=OFF.
//  FSM: OFF, CLEAR, SPAWN, WAIT_MOVE, SHIFT, CHECK, OVER.
//  - start (any state, priority below rst) -> CLEAR next cycle: board=0, score=0.
//    CLEAR -> SPAWN twice -> CHECK -> WAIT_MOVE.
//  - WAIT_MOVE: dir_ready=1, game_state=01. Move accepted on dir_valid&dir_ready.
//    dir not one-hot -> consumed, ignored, stay in WAIT_MOVE.
//  - SHIFT: exactly N cycles, one row (left/right) or column (up/down) per cycle.
//    Line compacts toward move side; equal adjacent pair merges once per move,
//    exponent+1, merged cell not re-merged ([1,1,1,1] left -> [2,2,0,0]).
//    Each merge adds 2^(new exp) to score; score saturates at 2^SCORE_W-1.
//  - After SHIFT: board changed -> SPAWN; unchanged -> WAIT_MOVE, no spawn, score unchanged.
//  - SPAWN: start index = LFSR mod N*N, scan forward one cell/cycle with wrap until empty;
//    writes exp 2 if LFSR[15:12]==0, else exp 1. Latency 1..N*N cycles.
//    No empty cell -> skip write.
//  - CHECK (1 cycle):
//    any cell == WIN_EXP -> game_state=10, OVER (win has priority over lose);
//    else no empty cell and no equal horizontal/vertical neighbours -> game_state=11, OVER;
//    else WAIT_MOVE.
//  - OVER: dir_ready=0; board/score/game_state held until start or rst.
//  - load_en honoured only in OFF, WAIT_MOVE or OVER: board<=load_board, score kept, -> CHECK.
//  - busy=1 in CLEAR, SPAWN, SHIFT, CHECK; 0 otherwise.
//  - LFSR x^16+x^14+x^13+x^11 advances every cycle except during reset.
//  - Reset mid-SHIFT/SPAWN: board, score and state return to reset values next cycle;
//    no partial write survives.
// TESTING
//  1 rst, start -> within 2+2*N*N+1 cycles: exactly 2 non-zero cells, each exp 1 or 2;
//    score=0, game_state=01, dir_ready=1.
//  2 load row0=[1,1,2,2], rest 0; dir=left -> row0=[2,3,0,0], score=12;
//    one new tile outside row0 cols 0-1; busy for N+spawn+1 cycles.
//  3 load row0=[1,1,1,1]; dir=left -> row0=[2,2,0,0], score=8 (no double merge).
//  4 load row0=[1,2,0,0], rest 0; dir=left -> board unchanged, no spawn, score unchanged;
//    dir_ready=1 again N+1 cycles after acceptance.
//  5 load row0=[10,10,0,0]; dir=left -> cell(0,0)=11, score+=2048, game_state=10, dir_ready=0;
//    later start -> game_state=01.
//  6 load full checkerboard of exp 1/2 -> game_state=11 after CHECK;
//    dir=0100, any value -> ignored (dir_ready=0).
//  7 assert rst during SHIFT cycle 2 -> next cycle: board=0, score=0, game_state=00.

Source files
------------

// File: rtl/game2048_nxn_ctrl.sv
// game2048_nxn_ctrl: NxN 2048 engine with line-serial slide/merge, LFSR tile spawner,
// win/lose detection and a valid/ready move interface.
module game2048_nxn_ctrl #(
    parameter int          N       = 4,
    parameter int          TILE_W  = 4,
    parameter int          WIN_EXP = 11,
    parameter int          SCORE_W = 20,
    parameter logic [15:0] SEED    = 16'hACE1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       dir_valid,
    input  logic [3:0]                 dir,
    output logic                       dir_ready,
    input  logic                       load_en,
    input  logic [N*N*TILE_W-1:0]      load_board,
    output logic [N*N*TILE_W-1:0]      board,
    output logic [SCORE_W-1:0]         score,
    output logic [1:0]                 game_state,
    output logic                       busy
);
    localparam int NN = N * N;
    localparam int IW = $clog2(NN);
    localparam int LW = $clog2(N);
    localparam int GW = (1 << TILE_W) + $clog2(N) + 1;
    localparam int SW = (SCORE_W > GW ? SCORE_W : GW) + 1;

    typedef enum logic [2:0] {OFF, CLEAR, SPAWN, WAIT_MOVE, SHIFT, CHECK, OVER} state_t;
    state_t state, state_nx;

    logic [TILE_W-1:0] cells [NN];
    logic [TILE_W-1:0] lin [N];
    logic [TILE_W-1:0] lout [N];
    logic [TILE_W-1:0] prev;
    logic [IW-1:0]     lidx [N];
    logic [IW-1:0]     sp_idx, sp_cnt, sp_cur, sp_nx;
    logic [LW-1:0]     line, pos;
    logic [15:0]       lfsr;
    logic [1:0]        dsel;
    logic [GW-1:0]     gain;
    logic [SW-1:0]     sum;
    logic [SCORE_W-1:0] score_nx;
    logic moved, moved_nx, lchg, line_last, sp_first, sp_two, sp_done;
    logic dir_ok, load_ok, win, full, pair;

    assign dir_ok    = (dir != 4'd0) && ((dir & (dir - 4'd1)) == 4'd0);
    assign load_ok   = state inside {OFF, WAIT_MOVE, OVER};
    assign line_last = line == LW'(N - 1);
    assign moved_nx  = moved | lchg;

    // dsel[1]: horizontal move, dsel[0]: line is read from the far end
    always_comb begin
        for (int k = 0; k < N; k++) begin
            lidx[k] = dsel[1] ? IW'(int'(line) * N + (dsel[0] ? N - 1 - k : k))
                              : IW'((dsel[0] ? N - 1 - k : k) * N + int'(line));
            lin[k]  = cells[lidx[k]];
        end
    end

    // Compact toward index 0; a pending tile merges with at most one later equal tile
    always_comb begin
        pos  = '0;
        prev = '0;
        gain = '0;
        lchg = 1'b0;
        for (int k = 0; k < N; k++) lout[k] = '0;
        for (int k = 0; k < N; k++) begin
            if (lin[k] != '0) begin
                if (prev == lin[k]) begin
                    lout[pos] = lin[k] + TILE_W'(1);
                    gain      = gain + (GW'(1) << (lin[k] + TILE_W'(1)));
                    pos       = pos + LW'(1);
                    prev      = '0;
                end else begin
                    if (prev != '0) begin
                        lout[pos] = prev;
                        pos       = pos + LW'(1);
                    end
                    prev = lin[k];
                end
            end
        end
        if (prev != '0) lout[pos] = prev;
        for (int k = 0; k < N; k++) lchg = lchg | (lout[k] != lin[k]);
        sum      = SW'(score) + SW'(gain);
        score_nx = sum > SW'({SCORE_W{1'b1}}) ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];
    end

    assign sp_cur  = sp_first ? IW'(lfsr % 16'(NN)) : sp_idx;
    assign sp_nx   = sp_cur == IW'(NN - 1) ? '0 : sp_cur + IW'(1);
    assign sp_done = (cells[sp_cur] == '0) || (sp_cnt == IW'(NN - 1));

    always_comb begin
        win  = 1'b0;
        full = 1'b1;
        pair = 1'b0;
        for (int j = 0; j < NN; j++) begin
            win  = win | (cells[j] == TILE_W'(WIN_EXP));
            full = full & (cells[j] != '0);
        end
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N - 1; c++)
                pair = pair | (cells[r*N+c] == cells[r*N+c+1]) | (cells[c*N+r] == cells[(c+1)*N+r]);
    end

    always_ff @(posedge clk) begin
        if (rst) state <= OFF;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            CLEAR:     state_nx = SPAWN;
            SPAWN:     state_nx = (sp_done && !sp_two) ? CHECK : SPAWN;
            WAIT_MOVE: state_nx = (dir_valid && dir_ok) ? SHIFT : WAIT_MOVE;
            SHIFT:     state_nx = !line_last ? SHIFT : moved_nx ? SPAWN : WAIT_MOVE;
            CHECK:     state_nx = (win || (full && !pair)) ? OVER : WAIT_MOVE;
            default:   state_nx = state;
        endcase
        if (load_ok && load_en) state_nx = CHECK;
        if (start) state_nx = CLEAR;
    end

    always_comb begin
        dir_ready = state == WAIT_MOVE;
        busy      = state inside {CLEAR, SPAWN, SHIFT, CHECK};
        board     = '0;
        for (int j = 0; j < NN; j++) board[j*TILE_W +: TILE_W] = cells[j];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < NN; j++) cells[j] <= '0;
            score      <= '0;
            game_state <= 2'b00;
            lfsr       <= SEED;
            dsel       <= 2'b00;
            line       <= '0;
            moved      <= 1'b0;
            sp_first   <= 1'b1;
            sp_two     <= 1'b0;
            sp_idx     <= '0;
            sp_cnt     <= '0;
        end else begin
            lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
            if (state == CLEAR) begin
                for (int j = 0; j < NN; j++) cells[j] <= '0;
                score      <= '0;
                game_state <= 2'b01;
                sp_two     <= 1'b1;
                sp_first   <= 1'b1;
                sp_cnt     <= '0;
            end
            if (state == WAIT_MOVE && dir_valid && dir_ok) begin
                dsel  <= {dir[3] | dir[2], dir[3] | dir[1]};
                line  <= '0;
                moved <= 1'b0;
            end
            if (state == SHIFT) begin
                for (int k = 0; k < N; k++) cells[lidx[k]] <= lout[k];
                score <= score_nx;
                line  <= line + LW'(1);
                moved <= moved_nx;
            end
            if (state == SPAWN) begin
                if (sp_done) begin
                    if (cells[sp_cur] == '0) cells[sp_cur] <= (lfsr[15:12] == 4'd0) ? TILE_W'(2) : TILE_W'(1);
                    sp_two <= 1'b0;
                end
                sp_first <= sp_done;
                sp_idx   <= sp_nx;
                sp_cnt   <= sp_done ? '0 : sp_cnt + IW'(1);
            end
            if (state == CHECK) game_state <= win ? 2'b10 : (full && !pair) ? 2'b11 : 2'b01;
            if (load_ok && load_en)
                for (int j = 0; j < NN; j++) cells[j] <= load_board[j*TILE_W +: TILE_W];
        end
    end
endmodule

// File: tb/tb_game2048_nxn_ctrl.sv
// tb_game2048_nxn_ctrl: directed vectors for the 2048 engine (4x4, 12-bit score to reach saturation).
module tb_game2048_nxn_ctrl;
    localparam int N  = 4;
    localparam int NN = 16;
    localparam int SW = 12;

    logic clk = 1'b0;
    logic rst, start, dir_valid, load_en, dir_ready, busy;
    logic [3:0] dir;
    logic [63:0] load_board, board;
    logic [SW-1:0] score;
    logic [1:0] game_state;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    game2048_nxn_ctrl #(.N(N), .TILE_W(4), .WIN_EXP(11), .SCORE_W(SW), .SEED(16'hACE1)) dut (
        .clk(clk), .rst(rst), .start(start), .dir_valid(dir_valid), .dir(dir),
        .dir_ready(dir_ready), .load_en(load_en), .load_board(load_board), .board(board),
        .score(score), .game_state(game_state), .busy(busy)
    );

    typedef struct {
        logic [63:0] init;
        logic [3:0]  d;
        logic [63:0] expb;
        int          sc;
        bit          moved;
    } vec_t;
    vec_t vecs [8];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Non-zero expected cells must match; exactly `moved` extra tiles of exp 1/2 elsewhere
    task automatic chk_board(input string nm, input logic [63:0] expb, input bit moved);
        int extra;
        bit ok;
        logic [3:0] e, a;
        extra = 0;
        ok = 1'b1;
        for (int j = 0; j < NN; j++) begin
            e = expb[j*4 +: 4];
            a = board[j*4 +: 4];
            if (e != 4'd0) ok = ok & (a == e);
            else if (a != 4'd0) begin
                extra++;
                ok = ok & (a == 4'd1 || a == 4'd2);
            end
        end
        checks++;
        if (!ok || extra != int'(moved)) begin
            errors++;
            $display("FAIL %s: board %h expected %h plus %0d spawned tile(s)", nm, board, expb, moved);
        end
    endtask

    task automatic new_game(output int n);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (!dir_ready && n < 60) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic load(input logic [63:0] b);
        int n;
        load_board = b;
        load_en = 1'b1;
        @(negedge clk);
        load_en = 1'b0;
        n = 0;
        while (busy && n < 10) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic move(input logic [3:0] d, output int n);
        dir = d;
        dir_valid = 1'b1;
        @(negedge clk);
        dir_valid = 1'b0;
        n = 0;
        while (busy && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        int n, cnt, bad;
        logic [63:0] cb;
        rst = 1'b1; start = 1'b0; dir_valid = 1'b0; dir = 4'd0; load_en = 1'b0; load_board = '0;
        vecs[0] = '{64'h0000_0000_0000_2211, 4'b0100, 64'h0000_0000_0000_0032, 12, 1'b1};
        vecs[1] = '{64'h0000_0000_0000_1111, 4'b0100, 64'h0000_0000_0000_0022,  8, 1'b1};
        vecs[2] = '{64'h0000_0000_0000_0021, 4'b0100, 64'h0000_0000_0000_0021,  0, 1'b0};
        vecs[3] = '{64'h0000_0000_0000_2211, 4'b1000, 64'h0000_0000_0000_3200, 12, 1'b1};
        vecs[4] = '{64'h0002_0001_0000_0001, 4'b0001, 64'h0000_0000_0002_0002,  4, 1'b1};
        vecs[5] = '{64'h0000_0020_0020_0020, 4'b0010, 64'h0030_0020_0000_0000,  8, 1'b1};
        vecs[6] = '{64'h0000_4000_3202_0000, 4'b0100, 64'h0000_0004_0033_0000,  8, 1'b1};
        vecs[7] = '{64'h0000_0000_0000_0021, 4'b0001, 64'h0000_0000_0000_0021,  0, 1'b0};
        repeat (3) @(negedge clk);
        chk("reset board", board, 0);
        chk("reset score", score, 0);
        chk("reset state", game_state, 0);
        chk("reset ready", dir_ready, 0);
        chk("reset busy", busy, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("off ready", dir_ready, 0);

        new_game(n);
        chk("start latency", n <= 2 + 2*NN + 1, 1);
        cnt = 0;
        bad = 0;
        for (int j = 0; j < NN; j++)
            if (board[j*4 +: 4] != 4'd0) begin
                cnt++;
                if (board[j*4 +: 4] > 4'd2) bad++;
            end
        chk("start tile count", cnt, 2);
        chk("start tile values", bad, 0);
        chk("start score", score, 0);
        chk("start state", game_state, 2'b01);
        chk("start ready", dir_ready, 1);

        foreach (vecs[i]) begin
            new_game(n);
            load(vecs[i].init);
            chk($sformatf("v%0d ready before move", i), dir_ready, 1);
            move(vecs[i].d, n);
            chk_board($sformatf("v%0d board", i), vecs[i].expb, vecs[i].moved);
            chk($sformatf("v%0d score", i), score, vecs[i].sc);
            chk($sformatf("v%0d busy cycles ok(n=%0d)", i, n),
                vecs[i].moved ? (n >= N + 2 && n <= N + 1 + NN) : (n == N), 1);
            chk($sformatf("v%0d ready after", i), dir_ready, 1);
            chk($sformatf("v%0d state", i), game_state, 2'b01);
        end

        // non-one-hot directions are consumed without effect
        new_game(n);
        load(64'h0000_0000_0000_0021);
        foreach (vecs[i]) if (i < 2) begin
            dir = (i == 0) ? 4'b0011 : 4'b0000;
            dir_valid = 1'b1;
            @(negedge clk);
            dir_valid = 1'b0;
            chk($sformatf("bad dir %0d ready", i), dir_ready, 1);
            chk($sformatf("bad dir %0d busy", i), busy, 0);
            chk($sformatf("bad dir %0d board", i), board, 64'h21);
        end

        // win, load in OVER, score saturation, restart
        new_game(n);
        load(64'h0000_0000_0000_00AA);
        move(4'b0100, n);
        chk_board("win board", 64'h0000_0000_0000_000B, 1'b1);
        chk("win score", score, 2048);
        chk("win state", game_state, 2'b10);
        chk("win ready", dir_ready, 0);
        load(64'h0000_0000_0000_AAAA);
        chk("reload in over state", game_state, 2'b01);
        chk("reload keeps score", score, 2048);
        move(4'b0100, n);
        chk_board("sat board", 64'h0000_0000_0000_00BB, 1'b1);
        chk("saturated score", score, 4095);
        chk("sat win state", game_state, 2'b10);
        cb = board;
        dir = 4'b1000;
        dir_valid = 1'b1;
        repeat (2) @(negedge clk);
        dir_valid = 1'b0;
        chk("over holds board", board, cb);
        new_game(n);
        chk("restart state", game_state, 2'b01);
        chk("restart score", score, 0);

        // checkerboard of 1/2: full with no merges -> lose
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                cb[(r*N+c)*4 +: 4] = ((r + c) % 2 == 1) ? 4'd2 : 4'd1;
        load(cb);
        chk("lose state", game_state, 2'b11);
        chk("lose ready", dir_ready, 0);
        dir = 4'b0100;
        dir_valid = 1'b1;
        @(negedge clk);
        dir_valid = 1'b0;
        @(negedge clk);
        chk("lose board held", board, cb);
        chk("lose state held", game_state, 2'b11);
        chk("lose busy", busy, 0);

        // reset during the second SHIFT cycle
        new_game(n);
        load(64'h0000_0000_0000_2211);
        dir = 4'b0100;
        dir_valid = 1'b1;
        @(negedge clk);
        dir_valid = 1'b0;
        @(negedge clk);
        chk("mid shift score", score, 12);
        chk("mid shift busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst shift board", board, 0);
        chk("rst shift score", score, 0);
        chk("rst shift state", game_state, 0);
        chk("rst shift ready", dir_ready, 0);
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
